// File: rtl/constants_2D.sv
// Shared mesh-NoC constants for the 2D router: flit/direction widths, port codes
// and the modulo-5 port increment used by arbitration.
package constants_2D;

  localparam int unsigned SIZE      = 8;
  localparam int unsigned BITS_DIR  = 3;
  localparam int unsigned NUM_PORTS = 5;
  localparam int unsigned SUM_W     = BITS_DIR + 1;

  typedef logic [SIZE-1:0]     flit_t;
  typedef logic [BITS_DIR-1:0] port_idx_t;

  typedef enum logic [BITS_DIR-1:0] {
    DIR_LOCAL = BITS_DIR'(0),
    DIR_NORTH = BITS_DIR'(1),
    DIR_SOUTH = BITS_DIR'(2),
    DIR_EAST  = BITS_DIR'(3),
    DIR_WEST  = BITS_DIR'(4)
  } dir_e;

  // (a + b) mod NUM_PORTS for port indices already in range
  function automatic port_idx_t port_add(input port_idx_t a, input port_idx_t b);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(b);
    if (sum >= SUM_W'(NUM_PORTS)) begin
      sum = sum - SUM_W'(NUM_PORTS);
    end
    return sum[BITS_DIR-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter5.sv
// Five-way round-robin arbiter: first requester at or after ptr, wrapping mod 5.
module rr_arbiter5
  import constants_2D::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  port_idx_t            ptr,
  output port_idx_t            gnt_idx_c,
  output logic                 gnt_vld_c
);

  port_idx_t cand;

  always_comb begin
    gnt_idx_c = '0;
    gnt_vld_c = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = port_add(ptr, BITS_DIR'(i));
      if (!gnt_vld_c && req[cand]) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = cand;
      end
    end
  end

endmodule

// File: rtl/router_2.sv
// Five-port mesh flit router: 1-entry buffers per input and output, one table
// lookup per cycle chosen round-robin. Optional trace output under ROUTER_TRACE_EN.
module router_2
  import constants_2D::*;
#(
  parameter int ID = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [NUM_PORTS-1:0]      tx_req,
  input  logic [NUM_PORTS-1:0]      tx_ack,
  output logic [NUM_PORTS*SIZE-1:0] tx_data,
  input  logic [NUM_PORTS-1:0]      rx_req,
  output logic [NUM_PORTS-1:0]      rx_ack,
  input  logic [NUM_PORTS*SIZE-1:0] rx_data,
  output logic [SIZE-1:0]           table_addr,
  input  logic [BITS_DIR-1:0]       table_data
);

  if (ID < 0) begin : g_id_check
    $error("router_2: ID must be non-negative");
  end

  logic [NUM_PORTS-1:0] in_valid;
  logic [NUM_PORTS-1:0] out_valid;
  flit_t                in_data  [NUM_PORTS];
  flit_t                out_data [NUM_PORTS];
  port_idx_t            rr;

  port_idx_t gnt_idx;
  logic      gnt_vld;
  flit_t     sel_flit;
  logic      do_fwd;
  logic      do_drop;

  rr_arbiter5 u_arb (
    .req       (in_valid),
    .ptr       (rr),
    .gnt_idx_c (gnt_idx),
    .gnt_vld_c (gnt_vld)
  );

  // Forward only into an output that was empty at the start of the cycle, so an
  // output never frees and refills on the same edge.
  always_comb begin
    sel_flit   = in_data[gnt_idx];
    table_addr = gnt_vld ? sel_flit : '0;
    do_fwd     = 1'b0;
    do_drop    = 1'b0;
    if (gnt_vld) begin
      if (table_data > port_idx_t'(DIR_WEST)) begin
        do_drop = 1'b1;
      end else if (!out_valid[table_data]) begin
        do_fwd = 1'b1;
      end
    end
  end

  assign tx_req = out_valid;
  assign rx_ack = ~in_valid & {NUM_PORTS{~reset}};

  always_comb begin
    tx_data = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      tx_data[p*SIZE +: SIZE] = out_data[p];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_valid  <= '0;
      out_valid <= '0;
      rr        <= '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        in_data[p]  <= '0;
        out_data[p] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (rx_req[p] && !in_valid[p]) begin
          in_valid[p] <= 1'b1;
          in_data[p]  <= rx_data[p*SIZE +: SIZE];
        end
        if (out_valid[p] && tx_ack[p]) begin
          out_valid[p] <= 1'b0;
          out_data[p]  <= '0;
        end
      end
      if (do_fwd) begin
        out_valid[table_data] <= 1'b1;
        out_data[table_data]  <= sel_flit;
        in_valid[gnt_idx]     <= 1'b0;
        rr                    <= port_add(gnt_idx, BITS_DIR'(1));
      end
      if (do_drop) begin
        in_valid[gnt_idx] <= 1'b0;
        rr                <= port_add(gnt_idx, BITS_DIR'(1));
      end
    end
  end

`ifdef ROUTER_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && do_fwd) begin
      $display("router %0d: in %0d -> out %0d flit %02h", ID, gnt_idx, table_data, sel_flit);
    end
    if (!reset && do_drop) begin
      $display("router %0d: drop in %0d flit %02h", ID, gnt_idx, sel_flit);
    end
  end
`else
`endif

endmodule

// File: tb/tb_router_2.sv
// Self-checking bench for router_2: cycle-level behavioural model plus directed
// scenarios with literal expectations, followed by a randomized phase.
module tb_router_2;
  import constants_2D::*;

  logic                      clk;
  logic                      reset;
  logic [NUM_PORTS-1:0]      tx_req, tx_ack, rx_req, rx_ack;
  logic [NUM_PORTS*SIZE-1:0] tx_data, rx_data;
  logic [SIZE-1:0]           table_addr;
  logic [BITS_DIR-1:0]       table_data;

  logic [BITS_DIR-1:0] route_tbl [2**SIZE];
  assign table_data = route_tbl[table_addr];

  router_2 #(.ID(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_req     (tx_req),
    .tx_ack     (tx_ack),
    .tx_data    (tx_data),
    .rx_req     (rx_req),
    .rx_ack     (rx_ack),
    .rx_data    (rx_data),
    .table_addr (table_addr),
    .table_data (table_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state: buffers as plain arrays, arbitration pointer as an int
  bit              m_in_v  [NUM_PORTS];
  logic [SIZE-1:0] m_in_d  [NUM_PORTS];
  bit              m_out_v [NUM_PORTS];
  logic [SIZE-1:0] m_out_d [NUM_PORTS];
  int              m_rr;
  int              n_vec;
  int              n_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int p = 0; p < NUM_PORTS; p++) begin
      m_in_v[p]  = 1'b0;
      m_in_d[p]  = '0;
      m_out_v[p] = 1'b0;
      m_out_d[p] = '0;
    end
    m_rr = 0;
  endtask

  // Called at a negedge with inputs already driven: compare, then step model one edge.
  task automatic cycle();
    logic [NUM_PORTS-1:0]      e_req, e_ack;
    logic [NUM_PORTS*SIZE-1:0] e_data;
    logic [SIZE-1:0]           e_addr;
    bit                        busy [NUM_PORTS];
    int                        sel;
    int                        d;
    sel    = -1;
    e_req  = '0;
    e_ack  = '0;
    e_data = '0;
    e_addr = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (sel < 0 && m_in_v[(m_rr + k) % NUM_PORTS]) sel = (m_rr + k) % NUM_PORTS;
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      e_req[p] = m_out_v[p];
      e_ack[p] = !m_in_v[p];
      e_data[p*SIZE +: SIZE] = m_out_d[p];
      busy[p] = m_out_v[p];
    end
    if (sel >= 0) e_addr = m_in_d[sel];
    #1;
    chk("tx_req", 64'(tx_req), 64'(e_req));
    chk("rx_ack", 64'(rx_ack), 64'(e_ack));
    chk("tx_data", 64'(tx_data), 64'(e_data));
    chk("table_addr", 64'(table_addr), 64'(e_addr));
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (m_out_v[p] && tx_ack[p]) begin
        m_out_v[p] = 1'b0;
        m_out_d[p] = '0;
      end
    end
    if (sel >= 0) begin
      d = int'(route_tbl[m_in_d[sel]]);
      if (d >= NUM_PORTS) begin
        m_in_v[sel] = 1'b0;
        m_rr = (sel + 1) % NUM_PORTS;
      end else if (!busy[d]) begin
        m_out_v[d] = 1'b1;
        m_out_d[d] = m_in_d[sel];
        m_in_v[sel] = 1'b0;
        m_rr = (sel + 1) % NUM_PORTS;
      end
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rx_req[p] && e_ack[p]) begin
        m_in_v[p] = 1'b1;
        m_in_d[p] = rx_data[p*SIZE +: SIZE];
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_and_check(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_rst_tx_req"}, 64'(tx_req), 64'(0));
    chk({tag, "_rst_rx_ack"}, 64'(rx_ack), 64'(0));
    chk({tag, "_rst_tx_data"}, 64'(tx_data), 64'(0));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    #1;
    chk({tag, "_rel_tx_req"}, 64'(tx_req), 64'(0));
    chk({tag, "_rel_rx_ack"}, 64'(rx_ack), 64'(5'h1F));
  endtask

  task automatic send(input int p, input logic [SIZE-1:0] f);
    rx_req[p] = 1'b1;
    rx_data[p*SIZE +: SIZE] = f;
  endtask

  task automatic fill_all_outputs();
    rx_req = '0;
    tx_ack = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      route_tbl[8'h10 + p] = BITS_DIR'(p);
      send(p, SIZE'(8'h10 + p));
    end
    cycle();
    rx_req = '0;
  endtask

  logic [NUM_PORTS-1:0] rr_exp [NUM_PORTS];

  initial begin
    n_vec = 0;
    n_err = 0;
    rx_req = '0;
    rx_data = '0;
    tx_ack = '0;
    for (int i = 0; i < 2**SIZE; i++) route_tbl[i] = '0;
    rr_exp[0] = 5'b00001; rr_exp[1] = 5'b00011; rr_exp[2] = 5'b00111;
    rr_exp[3] = 5'b01111; rr_exp[4] = 5'b11111;

    reset_and_check("init");

    // single flit local -> east
    route_tbl[8'h03] = 3'd3;
    send(0, 8'h03);
    cycle();
    rx_req = '0;
    chk("lit_held_rx_ack", 64'(rx_ack), 64'(5'h1E));
    chk("lit_lookup_addr", 64'(table_addr), 64'(8'h03));
    cycle();
    chk("lit_first_tx_req", 64'(tx_req), 64'(5'b01000));
    chk("lit_first_lane3", 64'(tx_data[3*SIZE +: SIZE]), 64'(8'h03));
    tx_ack = 5'h1F;
    cycle();
    chk("lit_first_drain", 64'(tx_req), 64'(0));

    // backpressure on east
    tx_ack = 5'h17;
    route_tbl[8'h05] = 3'd3;
    route_tbl[8'h06] = 3'd3;
    send(0, 8'h05);
    cycle();
    rx_req = '0;
    cycle();
    send(0, 8'h06);
    cycle();
    rx_req = '0;
    cycle();
    chk("lit_bp_tx_req", 64'(tx_req), 64'(5'b01000));
    chk("lit_bp_lane3", 64'(tx_data[3*SIZE +: SIZE]), 64'(8'h05));
    chk("lit_bp_rx_ack", 64'(rx_ack), 64'(5'h1E));
    chk("lit_bp_addr", 64'(table_addr), 64'(8'h06));
    tx_ack = 5'h1F;
    cycle();
    chk("lit_bp_freed", 64'(tx_req), 64'(0));
    cycle();
    chk("lit_bp_second_req", 64'(tx_req), 64'(5'b01000));
    chk("lit_bp_second_lane3", 64'(tx_data[3*SIZE +: SIZE]), 64'(8'h06));
    cycle();

    // round-robin across all five inputs from rr = 0
    reset_and_check("rr");
    fill_all_outputs();
    for (int k = 0; k < NUM_PORTS; k++) begin
      cycle();
      chk("lit_rr_tx_req", 64'(tx_req), 64'(rr_exp[k]));
      chk("lit_rr_lane", 64'(tx_data[k*SIZE +: SIZE]), 64'(8'h10 + k));
    end
    tx_ack = 5'h1F;
    cycle();
    chk("lit_rr_drain", 64'(tx_req), 64'(0));

    // contention on local output
    route_tbl[8'h21] = 3'd0;
    route_tbl[8'h22] = 3'd0;
    send(1, 8'h21);
    send(2, 8'h22);
    cycle();
    rx_req = '0;
    cycle();
    chk("lit_cont_first", 64'(tx_data[0 +: SIZE]), 64'(8'h21));
    chk("lit_cont_rx_ack1", 64'(rx_ack), 64'(5'b11011));
    cycle();
    chk("lit_cont_gap", 64'(tx_req), 64'(0));
    cycle();
    chk("lit_cont_second_req", 64'(tx_req), 64'(5'b00001));
    chk("lit_cont_second", 64'(tx_data[0 +: SIZE]), 64'(8'h22));
    chk("lit_cont_rx_ack2", 64'(rx_ack), 64'(5'h1F));
    cycle();

    // invalid route discarded, next input served
    route_tbl[8'hAA] = 3'd7;
    route_tbl[8'h44] = 3'd4;
    send(3, 8'hAA);
    send(4, 8'h44);
    cycle();
    rx_req = '0;
    cycle();
    chk("lit_drop_tx_req", 64'(tx_req), 64'(0));
    chk("lit_drop_rx_ack", 64'(rx_ack), 64'(5'b01111));
    chk("lit_drop_next_addr", 64'(table_addr), 64'(8'h44));
    cycle();
    chk("lit_drop_next_req", 64'(tx_req), 64'(5'b10000));
    chk("lit_drop_next_lane", 64'(tx_data[4*SIZE +: SIZE]), 64'(8'h44));
    cycle();

    // randomized traffic, including some invalid routes
    for (int i = 0; i < 2**SIZE; i++) begin
      route_tbl[i] = ($urandom_range(0, 9) < 8) ? BITS_DIR'($urandom_range(0, 4))
                                                : BITS_DIR'($urandom_range(5, 7));
    end
    for (int c = 0; c < 3000; c++) begin
      rx_req = NUM_PORTS'($urandom);
      tx_ack = NUM_PORTS'($urandom) | NUM_PORTS'($urandom);
      for (int p = 0; p < NUM_PORTS; p++) rx_data[p*SIZE +: SIZE] = SIZE'($urandom);
      cycle();
    end
    rx_req = '0;

    // reset with every output full
    reset_and_check("pre_fill");
    fill_all_outputs();
    for (int k = 0; k < NUM_PORTS; k++) cycle();
    chk("lit_full_tx_req", 64'(tx_req), 64'(5'h1F));
    #2;
    reset_and_check("full");
    tx_ack = '0;
    cycle();
    cycle();
    chk("lit_after_reset_empty", 64'(tx_req), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
